// File: rtl/sram_burst_reader_if.sv
// Request and read-stream handshake between sram_burst_reader (slave) and its client (master).
interface sram_burst_reader_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 19
);
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [LEN_W-1:0]  length;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;

   modport master (
      output start, start_addr, length, rd_ready,
      input  busy, done, rd_data, rd_valid
   );

   modport slave (
      input  start, start_addr, length, rd_ready,
      output busy, done, rd_data, rd_valid
   );
endinterface

// File: rtl/sram_burst_reader.sv
// Read-only burst controller for a 256Kx16 asynchronous SRAM, streaming words over valid/ready.
// Defining SRAM_RD_CHECKSUM_EN adds a running per-burst checksum output.
module sram_burst_reader #(
   parameter int ADDR_W      = 18,
   parameter int DATA_W      = 16,
   parameter int LEN_W       = 19,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               CLOCK_50,
   input  logic               RESET_N,
   sram_burst_reader_if.slave ctl,
   output logic [ADDR_W-1:0]  SRAM_ADDR,
   inout  wire  [DATA_W-1:0]  SRAM_DQ,
   output logic               SRAM_WE_N,
   output logic               SRAM_OE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N
`ifdef SRAM_RD_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0]  checksum
`endif
);
   localparam int                WAIT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_OUT    = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [ADDR_W-1:0] addr_r, addr_nxt_s;
   logic [LEN_W-1:0]  remaining_r, remaining_nxt_s;
   logic [WAIT_W-1:0] wait_r, wait_nxt_s;
   logic [DATA_W-1:0] data_r, data_nxt_s;
   logic              busy_r, done_r, valid_r, oe_n_r, ce_n_r;
   logic              accept_s, xfer_s;

   // The data bus is never driven; this block only reads the SRAM.
   assign SRAM_DQ   = {DATA_W{1'bz}};
   assign SRAM_WE_N = 1'b1;
   assign SRAM_ADDR = addr_r;
   assign SRAM_OE_N = oe_n_r;
   assign SRAM_CE_N = ce_n_r;
   assign SRAM_UB_N = ce_n_r;
   assign SRAM_LB_N = ce_n_r;
   assign ctl.busy     = busy_r;
   assign ctl.done     = done_r;
   assign ctl.rd_valid = valid_r;
   assign ctl.rd_data  = data_r;

   // Next-state, address, count and capture logic.
   always_comb begin
      state_nxt_s     = state_r;
      addr_nxt_s      = addr_r;
      remaining_nxt_s = remaining_r;
      wait_nxt_s      = wait_r;
      data_nxt_s      = data_r;
      accept_s        = 1'b0;
      xfer_s          = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (ctl.start) begin
               accept_s = 1'b1;
               if (ctl.length != {LEN_W{1'b0}}) begin
                  addr_nxt_s      = ctl.start_addr;
                  remaining_nxt_s = ctl.length;
                  wait_nxt_s      = {WAIT_W{1'b0}};
                  state_nxt_s     = ST_ACCESS;
               end else begin
                  state_nxt_s = ST_DONE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (wait_r == WAIT_LAST) begin
               data_nxt_s      = SRAM_DQ;
               remaining_nxt_s = remaining_r - LEN_W'(1);
               state_nxt_s     = ST_OUT;
            end else begin
               wait_nxt_s = wait_r + WAIT_W'(1);
            end
         end
         ST_OUT: begin
            if (ctl.rd_ready) begin
               xfer_s = 1'b1;
               if (remaining_r != {LEN_W{1'b0}}) begin
                  addr_nxt_s  = addr_r + ADDR_W'(1);
                  wait_nxt_s  = {WAIT_W{1'b0}};
                  state_nxt_s = ST_ACCESS;
               end else begin
                  state_nxt_s = ST_DONE;
               end
            end else begin
               state_nxt_s = ST_OUT;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, datapath and registered status/strobe outputs decoded from the next state.
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state_r     <= ST_IDLE;
         addr_r      <= {ADDR_W{1'b0}};
         remaining_r <= {LEN_W{1'b0}};
         wait_r      <= {WAIT_W{1'b0}};
         data_r      <= {DATA_W{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         valid_r     <= 1'b0;
         oe_n_r      <= 1'b1;
         ce_n_r      <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         addr_r      <= addr_nxt_s;
         remaining_r <= remaining_nxt_s;
         wait_r      <= wait_nxt_s;
         data_r      <= data_nxt_s;
         busy_r      <= (state_nxt_s != ST_IDLE);
         done_r      <= (state_nxt_s == ST_DONE);
         valid_r     <= (state_nxt_s == ST_OUT);
         oe_n_r      <= (state_nxt_s != ST_ACCESS);
         ce_n_r      <= (state_nxt_s == ST_IDLE);
      end
   end

`ifdef SRAM_RD_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_r;

   assign checksum = checksum_r;

   // Modular sum of words handed off in the current burst.
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         checksum_r <= {DATA_W{1'b0}};
      end else if (accept_s) begin
         checksum_r <= {DATA_W{1'b0}};
      end else if (xfer_s) begin
         checksum_r <= checksum_r + data_r;
      end else begin
         checksum_r <= checksum_r;
      end
   end
`else
   logic unused_s;
   assign unused_s = accept_s ^ xfer_s;
`endif
endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader: queue-based word model plus literal timing/data expectations.
module tb_sram_burst_reader;
   logic        clk;
   logic        rst_n;
   logic [17:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_RD_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic [17:0] addr;
      logic [15:0] data;
   } word_t;
   word_t exp_q[$];

   logic [15:0] mem [0:262143];
   assign sram_dq = mem[sram_addr];

   sram_burst_reader_if #(.ADDR_W(18), .DATA_W(16), .LEN_W(19)) bus ();

   sram_burst_reader #(.ADDR_W(18), .DATA_W(16), .LEN_W(19), .WAIT_CYCLES(1)) dut (
      .CLOCK_50  (clk),
      .RESET_N   (rst_n),
      .ctl       (bus),
      .SRAM_ADDR (sram_addr),
      .SRAM_DQ   (sram_dq),
      .SRAM_WE_N (sram_we_n),
      .SRAM_OE_N (sram_oe_n),
      .SRAM_CE_N (sram_ce_n),
      .SRAM_UB_N (sram_ub_n),
      .SRAM_LB_N (sram_lb_n)
`ifdef SRAM_RD_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every cycle: strobes consistent with busy, and each word shown/addressed is the next one expected.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("we_n_high", 32'(sram_we_n), 32'd1);
         chk("ce_ub_lb", 32'({sram_ce_n, sram_ub_n, sram_lb_n}), 32'({3{~bus.busy}}));
         if (!sram_oe_n) begin
            chk("oe_no_valid", 32'(bus.rd_valid), 32'd0);
            chk("oe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("oe_addr", 32'(sram_addr), 32'(exp_q[0].addr));
         end
         if (bus.rd_valid) begin
            chk("valid_oe_high", 32'(sram_oe_n), 32'd1);
            chk("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               chk("rd_data", 32'(bus.rd_data), 32'(exp_q[0].data));
               chk("out_addr", 32'(sram_addr), 32'(exp_q[0].addr));
               if (bus.rd_ready) exp_q.delete(0);
            end
         end
      end
   end

   task automatic check_reset_vals(input string nm);
      chk({nm, "_busy"},  32'(bus.busy), 32'd0);
      chk({nm, "_done"},  32'(bus.done), 32'd0);
      chk({nm, "_valid"}, 32'(bus.rd_valid), 32'd0);
      chk({nm, "_data"},  32'(bus.rd_data), 32'd0);
      chk({nm, "_addr"},  32'(sram_addr), 32'd0);
      chk({nm, "_strb"},  32'({sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n, sram_we_n}), 32'h1F);
   endtask

   task automatic run_burst(input string nm, input logic [17:0] a, input logic [18:0] n,
                            input int stall_word, input int stall_cyc, input int exp_done_k,
                            input logic [15:0] first_word);
      int          k, done_k, first_k, oe_lows, widx, stall_left;
      logic [15:0] sum;
      logic [17:0] ai;
      sum = 16'h0;
      for (int i = 0; i < int'(n); i++) begin
         ai = a + 18'(i);
         exp_q.push_back({ai, mem[ai]});
         sum = sum + mem[ai];
      end
      @(posedge clk); #1;
      bus.start = 1'b1; bus.start_addr = a; bus.length = n;
      @(posedge clk); #1;
      bus.start = 1'b0;
      k = 1; done_k = 0; first_k = 0; oe_lows = 0; widx = 0; stall_left = stall_cyc;
      while (done_k == 0 && k <= 300) begin
         bus.start = 1'b0;
         if (!sram_oe_n) oe_lows++;
         if (k == 1) begin
            if (n != 19'd0) chk({nm, "_first_addr"}, 32'(sram_addr), 32'(a));
`ifdef SRAM_RD_CHECKSUM_EN
            chk({nm, "_cks_cleared"}, 32'(checksum), 32'd0);
`endif
         end
         if (bus.rd_valid && first_k == 0) begin
            first_k = k;
            chk({nm, "_first_word"}, 32'(bus.rd_data), 32'(first_word));
         end
         if (bus.rd_valid && widx == stall_word && stall_left > 0) begin
            bus.rd_ready = 1'b0;
            stall_left--;
         end else begin
            bus.rd_ready = 1'b1;
         end
         if (bus.rd_valid && bus.rd_ready) widx++;
         if (bus.done) begin
            done_k = k;
            bus.start = 1'b1; bus.start_addr = a; bus.length = 19'd5;
         end else if (k == 2 && bus.busy) begin
            bus.start = 1'b1; bus.start_addr = 18'h0; bus.length = 19'd7;
         end
         if (done_k == 0) begin
            @(posedge clk); #1;
            k++;
         end
      end
      chk({nm, "_done_cycle"}, 32'(done_k), 32'(exp_done_k));
      chk({nm, "_first_valid_cycle"}, 32'(first_k), (n == 19'd0) ? 32'd0 : 32'd2);
      chk({nm, "_oe_low_cycles"}, 32'(oe_lows), 32'(n));
      chk({nm, "_words_left"}, 32'(exp_q.size()), 32'd0);
`ifdef SRAM_RD_CHECKSUM_EN
      chk({nm, "_cks_done"}, 32'(checksum), 32'(sum));
`endif
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({nm, "_post_busy"}, 32'(bus.busy), 32'd0);
      chk({nm, "_post_done"}, 32'(bus.done), 32'd0);
      @(posedge clk); #1;
      chk({nm, "_idle_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 262144; i++) mem[i] = 16'(i) ^ 16'h5A5A;
      mem[13]       = 16'h0002;
      mem[18'h3FFFE] = 16'hA0A0;
      mem[18'h3FFFF] = 16'hB0B0;
      mem[18'h00000] = 16'hC0C0;
      mem[18'h00001] = 16'hD0D0;
      mem[200] = 16'h8000;
      mem[201] = 16'h8001;
      mem[202] = 16'h0003;
      bus.start = 1'b0; bus.start_addr = 18'h0; bus.length = 19'h0; bus.rd_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst_n = 1'b1;

      run_burst("single",  18'd13,    19'd1, -1, 0, 3,  16'h0002);
      run_burst("wrap",    18'h3FFFE, 19'd4, -1, 0, 9,  16'hA0A0);
      run_burst("stall",   18'h3FFFE, 19'd4,  1, 5, 14, 16'hA0A0);
      run_burst("zerolen", 18'd40,    19'd0, -1, 0, 1,  16'h0000);
      run_burst("cks",     18'd200,   19'd3, -1, 0, 7,  16'h8000);
`ifdef SRAM_RD_CHECKSUM_EN
      chk("cks_literal", 32'(checksum), 32'h0004);
`endif

      // Abort a burst with reset while the second word is being read.
      exp_q.push_back({18'd100, mem[100]});
      @(posedge clk); #1;
      bus.start = 1'b1; bus.start_addr = 18'd100; bus.length = 19'd4;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("abort_access1", 32'(sram_oe_n), 32'd0);
      @(posedge clk); #1;
      chk("abort_out1", 32'(bus.rd_valid), 32'd1);
      @(posedge clk); #1;
      chk("abort_access2", 32'(sram_oe_n), 32'd0);
      chk("abort_access2_addr", 32'(sram_addr), 32'd101);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset_vals("abort");
      exp_q.delete();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("abort_no_done", 32'(bus.done), 32'd0);
         chk("abort_idle", 32'(bus.busy), 32'd0);
      end
      run_burst("after_abort", 18'd300, 19'd2, -1, 0, 5, 16'(300) ^ 16'h5A5A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
